// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: TX FIFO and presentation sequencer feeding a UART shifter.
// Optional macro UART_TX_FIFO_THRESH_IRQ_EN adds a fill-level threshold interrupt.
`default_nettype none

module uart_tx_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       fifo_clr,
  input  logic                       tx_en,
  input  logic                       tx_ready,
  output logic                       tx_valid,
  output logic [DW-1:0]              tx_data,
  output logic [$clog2(DEPTH):0]     tx_fifo_ptr,
  output logic                       full,
  output logic                       empty,
  output logic                       overrun,
`ifdef UART_TX_FIFO_THRESH_IRQ_EN
  input  logic [1:0]                 tx_thresh,
  output logic                       tx_thresh_irq,
`endif
  input  logic                       overrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  state_t        state_q, state_d;

  logic full_w, pop_w, push_w, ovr_ev_w;

  assign full_w   = (count_q == CNT_DEPTH);
  assign pop_w    = (state_q == PRESENT) && tx_ready && !fifo_clr;
  // A pop in the same cycle frees the slot, so a write into a full FIFO is accepted.
  assign push_w   = wr_en && (!full_w || pop_w) && !fifo_clr;
  assign ovr_ev_w = wr_en && full_w && !pop_w && !fifo_clr;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (fifo_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_w) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_w)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_w && !pop_w)      count_d = count_q + CNT_ONE;
      else if (pop_w && !push_w) count_d = count_q - CNT_ONE;
    end
    if (overrun_clr) overrun_d = 1'b0;
    if (ovr_ev_w)    overrun_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if ((count_q != '0) && tx_en) state_d = PRESENT;
      PRESENT: if (tx_ready) state_d = ((count_d != '0) && tx_en) ? PRESENT : IDLE;
      default: state_d = IDLE;
    endcase
    if (fifo_clr) state_d = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (push_w) mem[wr_ptr_q] <= wr_data;
  end

  assign tx_valid    = (state_q == PRESENT);
  assign tx_data     = mem[rd_ptr_q];
  assign tx_fifo_ptr = count_q;
  assign full        = full_w;
  assign empty       = (count_q == '0);
  assign overrun     = overrun_q;

`ifdef UART_TX_FIFO_THRESH_IRQ_EN
  logic [AW:0] level_w;
  logic        thresh_irq_q;

  always_comb begin
    level_w = '0;
    case (tx_thresh)
      2'd1:    level_w = (AW+1)'(DEPTH / 4);
      2'd2:    level_w = (AW+1)'(DEPTH / 2);
      2'd3:    level_w = (AW+1)'((3 * DEPTH) / 4);
      default: level_w = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) thresh_irq_q <= 1'b0;
    else          thresh_irq_q <= (count_q <= level_w);
  end

  assign tx_thresh_irq = thresh_irq_q;
`endif

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo_ctrl.md
UART_TX_FIFO_CTRL -- requirements
Module: uart_tx_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, meaning TX FIFO entries; legal values are powers of two from 4 to 64.
REQ-002 Parameter DW, default 8, meaning character width in bits.
REQ-003 Port clock  input  1  meaning the single block clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-005 Port wr_en  input  1  meaning host write strobe, one character per asserted cycle.
REQ-006 Port wr_data  input  DW  meaning character written when wr_en=1.
REQ-007 Port fifo_clr  input  1  meaning synchronous flush of FIFO and sequencer.
REQ-008 Port tx_en  input  1  meaning the sequencer may start presenting characters.
REQ-009 Port tx_ready  input  1  meaning the transmitter shifter accepts a character.
REQ-010 Port tx_valid  output  1  meaning a character is presented to the shifter.
REQ-011 Port tx_data  output  DW  meaning the head-of-FIFO character.
REQ-012 Port tx_fifo_ptr  output  log2(DEPTH)+1  meaning current fill count, 0..DEPTH.
REQ-013 Port full / empty  output  1 each  meaning count==DEPTH / count==0.
REQ-014 Port overrun  output  1  meaning sticky flag for a write dropped while full.
REQ-015 Port overrun_clr  input  1  meaning clears overrun.

Function
REQ-016 Storage: DEPTH x DW register array; wr_ptr/rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH, from DEPTH-1 to 0.
REQ-017 Write: wr_en=1 and not full -> store at wr_ptr, wr_ptr+1, count+1 at the same edge.
REQ-018 Write while full with no pop in the same cycle -> data dropped, pointers unchanged, overrun=1 from the next cycle.
REQ-019 Write while full with a pop in the same cycle -> write accepted, count stays DEPTH, overrun unchanged.
REQ-020 Pop: the tx_valid&&tx_ready cycle -> rd_ptr+1, count-1; a simultaneous write and pop leaves count unchanged.
REQ-021 Sequencer FSM, states IDLE and PRESENT: tx_valid is a registered output equal to (state==PRESENT).
REQ-022 IDLE->PRESENT when count>0 and tx_en=1 at the edge; first tx_valid therefore follows a write into an empty FIFO by 2 edges.
REQ-023 PRESENT with tx_ready=0: hold; tx_valid and tx_data are stable; tx_en deassertion does not drop tx_valid.
REQ-024 PRESENT with tx_ready=1: pop; stay in PRESENT if count after the pop >0 and tx_en=1 (back-to-back, no bubble); otherwise go to IDLE.
REQ-025 tx_data = mem[rd_ptr] at all times; its value in IDLE has no required meaning.
REQ-026 fifo_clr has priority over wr_en and pop: pointers and count go to 0, FSM goes to IDLE, tx_valid=0 next cycle, and any presented character is abandoned.
REQ-027 overrun_clr clears overrun; a same-cycle overrun event wins and overrun stays 1.

Reset
REQ-028 reset_n=0 asynchronously forces wr_ptr=0, rd_ptr=0, count=0, FSM=IDLE, tx_valid=0, overrun=0, empty=1, full=0.
REQ-029 Array contents are not reset; tx_data is undefined until the first write.
REQ-030 reset_n asserted mid-handshake abandons the character; no pop is counted.

Configuration
REQ-031 Macro UART_TX_FIFO_THRESH_IRQ_EN defined: adds input tx_thresh[1:0] and output tx_thresh_irq.
REQ-032 tx_thresh selects level 0, DEPTH/4, DEPTH/2 or 3*DEPTH/4 for values 0..3.
REQ-033 tx_thresh_irq is registered, asserts the cycle after count<=level, and resets to 0.
REQ-034 Macro not defined: neither port exists and no threshold logic is present.

Verification
REQ-035 Bench covers: reset, tx_en=1, write 0xA5 with tx_ready=0 -> tx_fifo_ptr=1 after edge 1, tx_valid=1 after edge 2 with tx_data=0xA5, held until tx_ready=1, then empty=1 and tx_valid=0.
REQ-036 Bench covers: write 17 characters 0x00..0x10 with tx_en=0 -> full=1 and tx_fifo_ptr=16 after 16 writes; 0x10 dropped and overrun=1; overrun_clr -> overrun=0.
REQ-037 Bench covers: 16 writes, then tx_en=1 with tx_ready tied to 1 -> 16 consecutive tx_valid cycles with data 0x00..0x0F in order, pointers wrap to 0, then empty=1.
REQ-038 Bench covers: full FIFO, same-cycle write 0x55 and pop -> tx_fifo_ptr remains 16, overrun=0, 0x55 emerges last.
REQ-039 Bench covers: PRESENT state with 5 entries, fifo_clr pulse -> tx_valid=0, tx_fifo_ptr=0 and empty=1 next cycle; a subsequent write restarts with 2-edge latency.
REQ-040 Bench covers: with UART_TX_FIFO_THRESH_IRQ_EN defined and tx_thresh=2, drain from 16 -> tx_thresh_irq rises exactly one cycle after tx_fifo_ptr reaches 8.
